// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared constants for the data-memory arbiter: default data/address
//   width, ownership state encodings, requester index constants and a
//   helper that maps a requester index to its ownership state.
package dmem_arbiter_pkg;

  // Default data and address width of the processor data path.
  localparam int DMEM_WL = 32;

  // Ownership state encodings (kept as plain constants for legacy tools).
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  // Requester indices: R0 is the processor load/store unit, R1 the loader/debug port.
  localparam logic REQ_R0 = 1'b0;
  localparam logic REQ_R1 = 1'b1;

  // Ownership state that corresponds to a given requester index.
  function automatic logic [1:0] own_state(input logic idx);
    return (idx == REQ_R1) ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_run.sv
// arb_run_counter
//   Saturating counter with synchronous clear, used by the arbiter to
//   count consecutive locked grants while the other requester waits.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   clr    - synchronous clear (takes priority over inc)
//   inc    - increment request; ignored once count reaches MAX
//   count  - current count value
module arb_run_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] SAT = W'(MAX);

  // Clear wins over increment; the count sticks at SAT until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter for a single data-memory port. Grants are
//   combinational (same cycle as the request), ties alternate using the
//   last-granted index, and a requester may lock the port for a burst.
//   A locked owner is forced to give way after MAXRUN consecutive grants
//   while the other requester waits. Read data is registered and flagged
//   with a one-cycle RVALID pulse on the edge after the granted read.
// Ports:
//   CLK, RST                    - clock (rising) and async active-low reset
//   Rx_REQ/WE/LOCK/ADDR/WD      - request, write enable, burst lock, address, write data
//   Rx_GNT                      - combinational grant
//   Rx_RVALID, Rx_RD            - registered read-data valid pulse and data
//   CPU_STALL                   - R0 requesting but not granted
//   M_WE, M_A, M_WD, M_RD       - single data-memory port (M_RD combinational from M_A)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WL     = DMEM_WL,
  parameter int MAXRUN = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          R0_REQ,
  input  logic          R1_REQ,
  input  logic          R0_WE,
  input  logic          R1_WE,
  input  logic          R0_LOCK,
  input  logic          R1_LOCK,
  input  logic [WL-1:0] R0_ADDR,
  input  logic [WL-1:0] R1_ADDR,
  input  logic [WL-1:0] R0_WD,
  input  logic [WL-1:0] R1_WD,
  output logic          R0_GNT,
  output logic          R1_GNT,
  output logic          R0_RVALID,
  output logic          R1_RVALID,
  output logic [WL-1:0] R0_RD,
  output logic [WL-1:0] R1_RD,
  output logic          CPU_STALL,
  output logic          M_WE,
  output logic [WL-1:0] M_A,
  output logic [WL-1:0] M_WD,
  input  logic [WL-1:0] M_RD
);

  localparam int            RW      = $clog2(MAXRUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAXRUN);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          last;
  logic [RW-1:0] run;
  logic          gnt_any;
  logic          gnt_idx;
  logic          gnt_lock;
  logic          own_idx;
  logic          own_req;
  logic          own_lock;
  logic          other_req;
  logic          other_lock;
  logic          run_inc;
  logic          run_clr;
  logic          gnt0;
  logic          gnt1;

  // View the request lines relative to the current owner so the OWN0 and
  // OWN1 cases share one piece of logic.
  assign own_idx    = (state == ST_OWN1);
  assign own_req    = own_idx ? R1_REQ  : R0_REQ;
  assign own_lock   = own_idx ? R1_LOCK : R0_LOCK;
  assign other_req  = own_idx ? R0_REQ  : R1_REQ;
  assign other_lock = own_idx ? R0_LOCK : R1_LOCK;

  // Grant selection and next ownership state, always decided from the
  // registered state so a new lock and a forced release in the same cycle
  // cannot interfere with each other.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = REQ_R0;
    gnt_lock  = 1'b0;
    state_nxt = ST_NONE;
    case (state)
      ST_OWN0, ST_OWN1: begin
        if (own_req && (run == RUN_MAX) && other_req) begin
          // Forced release: the waiting requester takes this cycle.
          gnt_any   = 1'b1;
          gnt_idx   = ~own_idx;
          state_nxt = other_lock ? own_state(~own_idx) : ST_NONE;
        end else if (own_req) begin
          gnt_any   = 1'b1;
          gnt_idx   = own_idx;
          state_nxt = own_lock ? state : ST_NONE;
        end else begin
          // Owner dropped its request: ownership ends and the other side
          // is served in this very cycle, without a dead cycle.
          gnt_any   = other_req;
          gnt_idx   = ~own_idx;
          state_nxt = ST_NONE;
        end
      end
      default: begin
        if (R0_REQ && R1_REQ) begin
          gnt_any = 1'b1;
          gnt_idx = ~last;
        end else if (R0_REQ) begin
          gnt_any = 1'b1;
          gnt_idx = REQ_R0;
        end else if (R1_REQ) begin
          gnt_any = 1'b1;
          gnt_idx = REQ_R1;
        end
        gnt_lock = (gnt_idx == REQ_R1) ? R1_LOCK : R0_LOCK;
        if (gnt_any && gnt_lock) begin
          state_nxt = own_state(gnt_idx);
        end
      end
    endcase
  end

  // Grants are gated by reset so nothing reaches memory while RST is low.
  assign gnt0      = RST & gnt_any & (gnt_idx == REQ_R0);
  assign gnt1      = RST & gnt_any & (gnt_idx == REQ_R1);
  assign R0_GNT    = gnt0;
  assign R1_GNT    = gnt1;
  assign CPU_STALL = R0_REQ & ~gnt0;

  // Memory port mux; everything is driven to zero when nobody is granted.
  always_comb begin
    M_WE = 1'b0;
    M_A  = '0;
    M_WD = '0;
    if (gnt0) begin
      M_WE = R0_WE;
      M_A  = R0_ADDR;
      M_WD = R0_WD;
    end else if (gnt1) begin
      M_WE = R1_WE;
      M_A  = R1_ADDR;
      M_WD = R1_WD;
    end
  end

  // The run count only grows while the owner is served and the other
  // requester is waiting; it restarts on any ownership change.
  assign run_inc = (state != ST_NONE) && gnt_any && (gnt_idx == own_idx) && other_req;
  assign run_clr = (state == ST_NONE) || (state_nxt != state) || !other_req;

  arb_run_counter #(
    .MAX (MAXRUN),
    .W   (RW)
  ) u_run (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (run_clr),
    .inc   (run_inc),
    .count (run)
  );

  // Ownership state and last-granted index. LAST resets to R1 so that the
  // first tie after reset goes to the processor.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_NONE;
      last  <= REQ_R1;
    end else begin
      state <= state_nxt;
      if (gnt_any) begin
        last <= gnt_idx;
      end
    end
  end

  // Read return path: capture M_RD on the edge closing a granted read.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      R0_RVALID <= 1'b0;
      R1_RVALID <= 1'b0;
      R0_RD     <= '0;
      R1_RD     <= '0;
    end else begin
      R0_RVALID <= gnt0 & ~R0_WE;
      R1_RVALID <= gnt1 & ~R1_WE;
      if (gnt0 && !R0_WE) begin
        R0_RD <= M_RD;
      end
      if (gnt1 && !R1_WE) begin
        R1_RD <= M_RD;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. A small memory model answers
//   the DUT memory port; the bench keeps its own copy of the memory
//   contents to predict read data. Expected reads are queued when a read
//   grant is expected and compared when RVALID should appear.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wd;
  } rq_t;

  typedef struct {
    int          idx;
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        r0_req, r1_req, r0_we, r1_we, r0_lock, r1_lock;
  logic [31:0] r0_addr, r1_addr, r0_wd, r1_wd;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [31:0] r0_rd, r1_rd;
  logic        cpu_stall;
  logic        m_we;
  logic [31:0] m_a, m_wd, m_rd;

  logic [31:0] mem       [0:255];
  logic [31:0] model_mem [0:255];
  exp_t        sbq[$];
  int          cyc;
  int          nChecks;
  int          nErrors;

  dmem_arbiter #(
    .WL     (32),
    .MAXRUN (4)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .R0_REQ    (r0_req),
    .R1_REQ    (r1_req),
    .R0_WE     (r0_we),
    .R1_WE     (r1_we),
    .R0_LOCK   (r0_lock),
    .R1_LOCK   (r1_lock),
    .R0_ADDR   (r0_addr),
    .R1_ADDR   (r1_addr),
    .R0_WD     (r0_wd),
    .R1_WD     (r1_wd),
    .R0_GNT    (r0_gnt),
    .R1_GNT    (r1_gnt),
    .R0_RVALID (r0_rvalid),
    .R1_RVALID (r1_rvalid),
    .R0_RD     (r0_rd),
    .R1_RD     (r1_rd),
    .CPU_STALL (cpu_stall),
    .M_WE      (m_we),
    .M_A       (m_a),
    .M_WD      (m_wd),
    .M_RD      (m_rd)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory seen by the DUT: combinational read, write on the rising edge.
  assign m_rd = mem[m_a[7:0]];

  always @(posedge clk) begin
    if (m_we) begin
      mem[m_a[7:0]] <= m_wd;
    end
  end

  // One comparison: count it and report any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic rq_t mk(input logic req, input logic we, input logic lock,
                             input logic [31:0] addr, input logic [31:0] wd);
    rq_t r;
    r.req  = req;
    r.we   = we;
    r.lock = lock;
    r.addr = addr;
    r.wd   = wd;
    return r;
  endfunction

  // A read request; WD carries a distinctive pattern so the M_WD mux is exercised.
  function automatic rq_t rdq(input logic [31:0] addr, input logic lock);
    return mk(1'b1, 1'b0, lock, addr, addr ^ 32'h5555_0000);
  endfunction

  function automatic rq_t idle();
    return mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endfunction

  task automatic drive(input rq_t a0, input rq_t a1);
    r0_req = a0.req; r0_we = a0.we; r0_lock = a0.lock; r0_addr = a0.addr; r0_wd = a0.wd;
    r1_req = a1.req; r1_we = a1.we; r1_lock = a1.lock; r1_addr = a1.addr; r1_wd = a1.wd;
  endtask

  // One arbitration cycle: drive both requesters just after the edge,
  // check the combinational outputs mid-cycle against the expected grant,
  // and record what the memory should return or now contain.
  task automatic applyStimulus(input string tag, input rq_t a0, input rq_t a1,
                               input logic eg0, input logic eg1);
    exp_t        e;
    logic        ewe;
    logic [31:0] ea;
    logic [31:0] ewd;
    @(posedge clk);
    #1;
    drive(a0, a1);
    #3;
    ewe = 1'b0;
    ea  = 32'h0;
    ewd = 32'h0;
    if (eg0) begin
      ewe = a0.we; ea = a0.addr; ewd = a0.wd;
    end else if (eg1) begin
      ewe = a1.we; ea = a1.addr; ewd = a1.wd;
    end
    checkOutput({tag, ".gnt0"}, {31'b0, r0_gnt}, {31'b0, eg0});
    checkOutput({tag, ".gnt1"}, {31'b0, r1_gnt}, {31'b0, eg1});
    checkOutput({tag, ".stall"}, {31'b0, cpu_stall}, {31'b0, a0.req & ~eg0});
    checkOutput({tag, ".m_we"}, {31'b0, m_we}, {31'b0, ewe});
    checkOutput({tag, ".m_a"}, m_a, ea);
    checkOutput({tag, ".m_wd"}, m_wd, ewd);
    if (eg0 || eg1) begin
      if (ewe) begin
        model_mem[ea[7:0]] = ewd;
      end else begin
        e.idx  = eg0 ? 0 : 1;
        e.due  = cyc + 1;
        e.data = model_mem[ea[7:0]];
        sbq.push_back(e);
      end
    end
  endtask

  // Read-return monitor: just after every edge, any read that was due must
  // show RVALID with the predicted data, and RVALID must be low otherwise.
  initial begin
    exp_t e;
    bit   got0;
    bit   got1;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      got0 = 1'b0;
      got1 = 1'b0;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        if (e.idx == 0) begin
          checkOutput("r0_rvalid", {31'b0, r0_rvalid}, 32'd1);
          checkOutput("r0_rd", r0_rd, e.data);
          got0 = 1'b1;
        end else begin
          checkOutput("r1_rvalid", {31'b0, r1_rvalid}, 32'd1);
          checkOutput("r1_rd", r1_rd, e.data);
          got1 = 1'b1;
        end
      end
      if (!got0) checkOutput("r0_rvalid_quiet", {31'b0, r0_rvalid}, 32'd0);
      if (!got1) checkOutput("r1_rvalid_quiet", {31'b0, r1_rvalid}, 32'd0);
    end
  end

  // Main sequence: reset, alternation, idle, forced releases, write/read,
  // burst abandonment and reset in the middle of a burst.
  initial begin
    nChecks = 0;
    nErrors = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 32'hC0DE_0000 | i;
      model_mem[i] = 32'hC0DE_0000 | i;
    end

    // Reset held with both sides requesting: nothing may be granted.
    rst = 1'b0;
    drive(mk(1'b1, 1'b1, 1'b0, 32'h4, 32'h1), rdq(32'h8, 1'b0));
    #12;
    checkOutput("rst.gnt0", {31'b0, r0_gnt}, 32'd0);
    checkOutput("rst.gnt1", {31'b0, r1_gnt}, 32'd0);
    checkOutput("rst.m_we", {31'b0, m_we}, 32'd0);
    checkOutput("rst.m_a", m_a, 32'h0);
    checkOutput("rst.stall", {31'b0, cpu_stall}, 32'd1);
    checkOutput("rst.rvalid0", {31'b0, r0_rvalid}, 32'd0);
    checkOutput("rst.rvalid1", {31'b0, r1_rvalid}, 32'd0);
    checkOutput("rst.rd0", r0_rd, 32'h0);
    checkOutput("rst.rd1", r1_rd, 32'h0);
    drive(idle(), idle());
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Both read continuously without lock: R0 wins the first tie, then alternate.
    for (int i = 0; i < 6; i++) begin
      applyStimulus("alt", rdq(32'h20 + i, 1'b0), rdq(32'h40 + i, 1'b0),
                    (i % 2) == 0, (i % 2) == 1);
    end

    // Idle: memory port quiet and no read data returned.
    for (int i = 0; i < 5; i++) begin
      applyStimulus("idle", idle(), idle(), 1'b0, 1'b0);
    end

    // R1 locks; R0 arrives on cycle 2 and waits exactly four cycles.
    applyStimulus("lk1_own", idle(), rdq(32'h50, 1'b1), 1'b0, 1'b1);
    applyStimulus("lk1_hold", idle(), rdq(32'h51, 1'b1), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("lk1_wait", rdq(32'h60, 1'b0), rdq(32'h52 + i, 1'b1), 1'b0, 1'b1);
    end
    applyStimulus("lk1_forced", rdq(32'h60, 1'b0), rdq(32'h56, 1'b1), 1'b1, 1'b0);
    applyStimulus("lk1_tie", rdq(32'h61, 1'b0), rdq(32'h57, 1'b1), 1'b0, 1'b1);
    applyStimulus("lk1_end", idle(), idle(), 1'b0, 1'b0);

    // R0 locks; a locking R1 is handed ownership by the forced release.
    applyStimulus("lk0_own", rdq(32'h70, 1'b1), idle(), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("lk0_wait", rdq(32'h71 + i, 1'b1), rdq(32'h80, 1'b1), 1'b1, 1'b0);
    end
    applyStimulus("lk0_forced", rdq(32'h75, 1'b1), rdq(32'h80, 1'b1), 1'b0, 1'b1);
    applyStimulus("own1_keep", rdq(32'h76, 1'b1), rdq(32'h81, 1'b1), 1'b0, 1'b1);
    applyStimulus("own1_end", idle(), idle(), 1'b0, 1'b0);

    // R1 writes, R0 reads the same word back.
    applyStimulus("wr", idle(), mk(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF), 1'b0, 1'b1);
    applyStimulus("rd_after_wr", rdq(32'h10, 1'b0), idle(), 1'b1, 1'b0);
    checkOutput("wr.model", model_mem[8'h10], 32'hDEAD_BEEF);

    // R0 burst ends by dropping REQ; R1 is served in that same cycle.
    applyStimulus("brst_own", rdq(32'h90, 1'b1), idle(), 1'b1, 1'b0);
    applyStimulus("brst_hold", rdq(32'h91, 1'b1), rdq(32'hA0, 1'b0), 1'b1, 1'b0);
    applyStimulus("brst_drop", idle(), rdq(32'hA0, 1'b0), 1'b0, 1'b1);
    applyStimulus("brst_end", idle(), idle(), 1'b0, 1'b0);

    // Reset mid-burst during an R1 locked read.
    applyStimulus("rst_burst", idle(), rdq(32'hB0, 1'b1), 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(rdq(32'hC0, 1'b0), rdq(32'hB1, 1'b1));
    #1;
    rst = 1'b0;
    #2;
    checkOutput("midrst.gnt0", {31'b0, r0_gnt}, 32'd0);
    checkOutput("midrst.gnt1", {31'b0, r1_gnt}, 32'd0);
    checkOutput("midrst.rvalid0", {31'b0, r0_rvalid}, 32'd0);
    checkOutput("midrst.rvalid1", {31'b0, r1_rvalid}, 32'd0);
    checkOutput("midrst.rd1", r1_rd, 32'h0);
    checkOutput("midrst.m_we", {31'b0, m_we}, 32'd0);
    checkOutput("midrst.stall", {31'b0, cpu_stall}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    drive(idle(), idle());
    rst = 1'b1;
    applyStimulus("rst_tie", rdq(32'hC0, 1'b0), rdq(32'hB1, 1'b1), 1'b1, 1'b0);
    applyStimulus("tail", idle(), idle(), 1'b0, 1'b0);
    applyStimulus("tail", idle(), idle(), 1'b0, 1'b0);
    #2;
    checkOutput("sb_empty", sbq.size(), 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
